// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: bit-serial a-b, LSB first, one bit per clock.
// Optional macro SERIAL_SUB_SAT_EN clamps a negative result to zero.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   begin one subtraction (accepted only when idle)
//   a, b   in   minuend / subtrahend, sampled on acceptance
//   busy   out  high while bits are being shifted
//   done   out  one-cycle pulse when diff/borrow are updated
//   diff   out  result, held until the next completion
//   borrow out  final borrow-out (a < b unsigned)

module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_bin;
  logic [CW-1:0]    r_cnt;

  logic             w_a0;
  logic             w_b0;
  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] w_diff_final;

  // One-bit full subtractor cell.
  assign w_a0   = r_a[0];
  assign w_b0   = r_b[0];
  assign w_d    = w_a0 ^ w_b0 ^ r_bin;
  assign w_bout = (~w_a0 & w_b0) |
                  (~(w_a0 ^ w_b0) & r_bin);

  // New bit enters at the MSB so the LSB ends up at bit 0.
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};

`ifdef SERIAL_SUB_SAT_EN
  assign w_diff_final = w_bout ? '0 : w_res_next;
`else
  assign w_diff_final = w_res_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_bin   <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      borrow  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_bin   <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= w_res_next;
          r_bin <= w_bout;
          r_cnt <= r_cnt + 1'b1;
          // Last bit: publish the result on the same edge.
          if (r_cnt == LAST) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            diff    <= w_diff_final;
            borrow  <= w_bout;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl: directed table, corner sequences and
// random operations against an arithmetic reference model.

module tb_serial_subtractor_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         br;
  } vec_t;

  vec_t tbl[6];

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  // Reference: {borrow, diff} from plain wide subtraction.
  function automatic logic [W:0] model(input logic [W-1:0] x,
                                       input logic [W-1:0] y);
    logic [W:0] r;
    r = {1'b0, x} - {1'b0, y};
`ifdef SERIAL_SUB_SAT_EN
    if (r[W]) r[W-1:0] = '0;
`endif
    return r;
  endfunction

  function automatic logic [W-1:0] sat(input logic [W-1:0] d,
                                       input logic br);
`ifdef SERIAL_SUB_SAT_EN
    return br ? '0 : d;
`else
    return br ? d : d;
`endif
  endfunction

  // One full operation; repulse >= 0 re-pulses start in that
  // SHIFT cycle (0-based) with different operands.
  task automatic do_op(input logic [W-1:0] ta,
                       input logic [W-1:0] tb_,
                       input int repulse,
                       input logic [W-1:0] ed,
                       input logic eb,
                       input string tag);
    int nb;
    @(negedge clk);
    start = 1'b1;
    a = ta;
    b = tb_;
    nb = 0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (i == repulse) begin
        start = 1'b1;
        a = 8'h10;
        b = 8'h01;
      end else begin
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
      end
      if (busy && !done) nb++;
    end
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("%s busy_len", tag), nb, W);
    chk($sformatf("%s done", tag), done, 1);
    chk($sformatf("%s busy@done", tag), busy, 0);
    chk($sformatf("%s diff", tag), diff, ed);
    chk($sformatf("%s borrow", tag), borrow, eb);
    @(negedge clk);
    chk($sformatf("%s done_drop", tag), done, 0);
    chk($sformatf("%s diff_hold", tag), diff, ed);
  endtask

  initial begin
    logic [W:0] m;
    int cnt;
    int last_c;
    int first_c;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
    tbl[2] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    tbl[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    tbl[4] = '{8'h80, 8'h01, 8'h7F, 1'b0};
    tbl[5] = '{8'h00, 8'h01, 8'hFF, 1'b1};

    rst = 1'b1;
    start = 1'b0;
    a = 8'hAA;
    b = 8'h55;
    repeat (2) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst diff", diff, 0);
    chk("rst borrow", borrow, 0);
    rst = 1'b0;

    for (int k = 0; k < 6; k++)
      do_op(tbl[k].a, tbl[k].b, -1,
            sat(tbl[k].d, tbl[k].br), tbl[k].br,
            $sformatf("tbl%0d", k));

    // Start re-pulsed mid-operation must be ignored.
    m = model(8'h20, 8'h07);
    do_op(8'h20, 8'h07, 3, m[W-1:0], m[W], "repulse");

    // Reset in 5th SHIFT cycle aborts with no done pulse.
    @(negedge clk);
    start = 1'b1;
    a = 8'h44;
    b = 8'h11;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort diff", diff, 0);
    chk("abort borrow", borrow, 0);
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("abort quiet", cnt, 0);
    m = model(8'h44, 8'h11);
    do_op(8'h44, 8'h11, -1, m[W-1:0], m[W], "post_abort");

    // Start held high: back-to-back, done every W+2 cycles.
    @(negedge clk);
    start = 1'b1;
    a = 8'h9C;
    b = 8'h3A;
    m = model(8'h9C, 8'h3A);
    cnt = 0;
    last_c = -1;
    first_c = -1;
    for (int c = 0; c < 46; c++) begin
      @(negedge clk);
      if (busy && done) chk("b2b overlap", 1, 0);
      if (done) begin
        if (first_c < 0) first_c = c;
        if (last_c >= 0) chk("b2b period", c - last_c, W + 2);
        chk("b2b diff", diff, m[W-1:0]);
        last_c = c;
        cnt++;
      end
    end
    start = 1'b0;
    chk("b2b first", first_c, W);
    chk("b2b count", cnt, 4);
    repeat (W + 4) @(negedge clk);

    // Random operations.
    for (int r = 0; r < 40; r++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (r % 8 == 0) ra = '0;
      if (r % 8 == 1) rb = '1;
      if (r % 8 == 2) rb = ra;
      m = model(ra, rb);
      do_op(ra, rb, -1, m[W-1:0], m[W], $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
